// File: rtl/alu_sequencer_if.sv
// Instruction-stream handshake between an upstream byte source and the
// sequencer. A byte moves on a rising clock edge when valid and ready are both high.
interface alu_sequencer_if;
   logic       instr_valid;
   logic [7:0] instr_data;
   logic       instr_ready;

   modport master (
      output instr_valid,
      output instr_data,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  instr_data,
      output instr_ready
   );
endinterface

// File: rtl/alu_sequencer.sv
// Small instruction sequencer that feeds an external combinational ALU.
// It fetches one instruction byte into IR and presents operands R[Rd] and R[Rs].
// It then writes the ALU result back into R[Rd].
// The load-immediate form takes a second byte and writes it to R[Rd] directly.
// Instruction byte layout: [7:5] opcode, [4:3] Rd, [2:1] Rs, [0] immediate flag.
module alu_sequencer #(
   parameter bit IMM_EN = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   alu_sequencer_if.slave        instr,
   output logic [7:0]            a,
   output logic [7:0]            b,
   output logic [2:0]            opcode,
   input  logic [7:0]            alu_out,
   output logic [7:0]            result,
   output logic                  result_valid,
   output logic                  busy
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_IMM   = 2'd1,
      S_EXEC  = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] ir;
   logic [7:0] rf [4];
   logic       ready_q;
   logic       busy_q;
   logic       xfer;
   logic [1:0] rd_idx;
   logic [1:0] rs_idx;

   assign rd_idx = ir[4:3];
   assign rs_idx = ir[2:1];

   // A byte is consumed only when both sides agree in the same cycle.
   assign xfer = instr.instr_valid && ready_q;

   // Ready and busy are registers, so both read 0 while reset is held.
   // Ready then rises at the first clock edge after reset is released.
   assign instr.instr_ready = ready_q;
   assign busy              = busy_q;

   // Operands and opcode are decoded straight from IR and the register file.
   // IR does not change during EXEC, so the ALU sees stable inputs.
   assign a      = rf[rd_idx];
   assign b      = rf[rs_idx];
   assign opcode = ir[7:5];

   // Sequencer FSM together with IR, the register file and the result registers.
   // NOTE: the register file is reset like any other flop. An aborted
   // instruction must leave every register at zero, not at stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_FETCH;
         ir           <= 8'h00;
         for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
         result       <= 8'h00;
         result_valid <= 1'b0;
         ready_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         // NOTE: every register here uses non-blocking assignment. The
         // EXEC write-back of R[Rd] therefore uses the ALU result produced
         // from the old R[Rd], even when Rd equals Rs.
         result_valid <= 1'b0;
         case (state)
            S_FETCH: begin
               if (xfer) begin
                  ir     <= instr.instr_data;
                  busy_q <= 1'b1;
                  if (IMM_EN && instr.instr_data[0]) begin
                     state   <= S_IMM;
                     ready_q <= 1'b1;
                  end else begin
                     state   <= S_EXEC;
                     ready_q <= 1'b0;
                  end
               end else begin
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            S_IMM: begin
               // The immediate byte goes to the register file only; IR keeps the instruction.
               if (xfer) begin
                  rf[rd_idx]   <= instr.instr_data;
                  result       <= instr.instr_data;
                  result_valid <= 1'b1;
                  state        <= S_FETCH;
                  ready_q      <= 1'b1;
                  busy_q       <= 1'b0;
               end
            end
            S_EXEC: begin
               rf[rd_idx]   <= alu_out;
               result       <= alu_out;
               result_valid <= 1'b1;
               state        <= S_FETCH;
               ready_q      <= 1'b1;
               busy_q       <= 1'b0;
            end
            default: begin
               state   <= S_FETCH;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
